// File: rtl/pipeline_stall_ctrl_pkg.sv
//==============================================================================
// Module : pipeline_stall_ctrl_pkg
// Brief  : Shared constants and state encodings for the pipeline stall controller.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package pipeline_stall_ctrl_pkg;

    // The bubble writes r0 only, so it can never act as a hazard source downstream.
    localparam logic [15:0] BUBBLE_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DSTALL = 2'd1,
        ST_CSTALL = 2'd2,
        ST_STUCK  = 2'd3
    } stall_state_e;

endpackage

`default_nettype wire

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
//==============================================================================
// Module : pipeline_stall_ctrl_sat_counter
// Brief  : Saturating up-counter with synchronous clear, asynchronous reset.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module pipeline_stall_ctrl_sat_counter #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] MAX_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != MAX_VAL)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/pipeline_stall_ctrl.sv
//==============================================================================
// Module : pipeline_stall_ctrl
// Brief  : Owns ID/EX/MEM/WB instruction registers, inserts bubbles on hazards,
//          tracks consecutive stalls. Optional macro STALL_PERF_EN adds
//          data/control stall performance counters.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int MAX_STALL = 8
`ifdef STALL_PERF_EN
    ,
    parameter int CNT_W     = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       if_instr,
    input  logic              data_hazard,
    input  logic              control_hazard,
    output logic              pc_en,
    output logic [15:0]       id_instr,
    output logic [15:0]       ex_instr,
    output logic [15:0]       mem_instr,
    output logic [15:0]       wb_instr,
    output logic [1:0]        stall_state,
    output logic              stall_timeout
`ifdef STALL_PERF_EN
    ,
    output logic [CNT_W-1:0]  data_stall_count,
    output logic [CNT_W-1:0]  ctrl_stall_count
`endif
);

    localparam int              SC_W       = $clog2(MAX_STALL + 1);
    localparam logic [SC_W-1:0] SC_MAX     = SC_W'(MAX_STALL);
    localparam logic [SC_W-1:0] SC_MAX_M1  = SC_W'(MAX_STALL - 1);

    stall_state_e     state_q, state_d;
    logic [15:0]      id_q, id_d;
    logic [15:0]      ex_q, ex_d;
    logic [15:0]      mem_q, mem_d;
    logic [15:0]      wb_q, wb_d;
    logic             timeout_q, timeout_d;
    logic [SC_W-1:0]  stall_cnt;
    logic             stall;
    logic             hits_max;

    assign stall    = data_hazard | control_hazard;
    // True on the edge where stall_cnt lands on (or stays at) MAX_STALL.
    assign hits_max = stall && (stall_cnt >= SC_MAX_M1);

    pipeline_stall_ctrl_sat_counter #(
        .WIDTH   (SC_W),
        .MAX_VAL (SC_MAX)
    ) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (stall),
        .clr_i   (!stall),
        .count_o (stall_cnt)
    );

    always_comb begin
        state_d   = ST_RUN;
        id_d      = if_instr;
        ex_d      = id_q;
        mem_d     = ex_q;
        wb_d      = mem_q;
        timeout_d = timeout_q | hits_max;
        if (data_hazard) begin
            id_d    = id_q;
            ex_d    = BUBBLE_INSTR;
            state_d = hits_max ? ST_STUCK : ST_DSTALL;
        end else if (control_hazard) begin
            id_d    = BUBBLE_INSTR;
            state_d = hits_max ? ST_STUCK : ST_CSTALL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RUN;
            id_q      <= BUBBLE_INSTR;
            ex_q      <= BUBBLE_INSTR;
            mem_q     <= BUBBLE_INSTR;
            wb_q      <= BUBBLE_INSTR;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            ex_q      <= ex_d;
            mem_q     <= mem_d;
            wb_q      <= wb_d;
            timeout_q <= timeout_d;
        end
    end

    assign pc_en         = !rst && !data_hazard && !control_hazard;
    assign id_instr      = id_q;
    assign ex_instr      = ex_q;
    assign mem_instr     = mem_q;
    assign wb_instr      = wb_q;
    assign stall_state   = state_q;
    assign stall_timeout = timeout_q;

`ifdef STALL_PERF_EN
    // Data hazard wins when both are high, so the control count excludes it.
    pipeline_stall_ctrl_sat_counter #(
        .WIDTH   (CNT_W),
        .MAX_VAL ('1)
    ) u_data_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (data_hazard),
        .clr_i   (1'b0),
        .count_o (data_stall_count)
    );

    pipeline_stall_ctrl_sat_counter #(
        .WIDTH   (CNT_W),
        .MAX_VAL ('1)
    ) u_ctrl_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (control_hazard && !data_hazard),
        .clr_i   (1'b0),
        .count_o (ctrl_stall_count)
    );
`endif

endmodule

`default_nettype wire
